// File: rtl/clb_cfg_loader_if.sv
// clb_cfg_loader_if: serial stream in, committed CLB configuration and status out
interface clb_cfg_loader_if #(parameter int CFG_W = 37);
   logic             CE;
   logic             DIN;
   logic [CFG_W-1:0] CFG;
   logic             DONE;
   logic             BUSY;
   logic             ERR;
   modport master (output CE, DIN, input CFG, DONE, BUSY, ERR);
   modport slave (input CE, DIN, output CFG, DONE, BUSY, ERR);
endinterface

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: hunts for a sync word, shifts in one parity-protected frame and
// commits it atomically to the CLB configuration bus.
module clb_cfg_loader #(
   parameter logic [7:0] SYNC = 8'hB2,
   parameter int CFG_W = 37,
   parameter int CNT_W = 6
) (
   input logic K,
   input logic RST,
   clb_cfg_loader_if.slave bus
);
   // mem, comboption, mux2..6, o2m x_0, o2m x_1, DQmux, floporlatch
   localparam logic [CFG_W-1:0] CFG_RST = CFG_W'({16'h0116, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                                  3'b000, 3'b111, 2'b00, 1'b0});
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);
   typedef enum logic [1:0] {HUNT, LOAD, PAR} state_t;
   state_t state, nxt;
   logic [7:0] sync_reg;
   logic [CFG_W-1:0] frame, cfg;
   logic [CNT_W-1:0] cnt;
   logic acc, done, err, hit, commit;
   always_comb begin
      nxt = state;
      hit = bus.CE && state == HUNT && {sync_reg[6:0], bus.DIN} == SYNC;
      commit = bus.CE && state == PAR && !(acc ^ bus.DIN);
      if (hit) nxt = LOAD;
      else if (bus.CE && state == LOAD && cnt == LAST) nxt = PAR;
      else if (bus.CE && state == PAR) nxt = HUNT;
   end
   always_ff @(posedge K or posedge RST)
      if (RST) state <= HUNT;
      else state <= nxt;
   always_ff @(posedge K or posedge RST)
      if (RST) begin
         sync_reg <= '0;
         frame <= '0;
         cnt <= '0;
         acc <= 1'b0;
         cfg <= CFG_RST;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= commit;
         if (bus.CE && state == HUNT) begin
            sync_reg <= {sync_reg[6:0], bus.DIN};
            if (hit) begin
               cnt <= '0;
               acc <= 1'b0;
               err <= 1'b0;
            end
         end else if (bus.CE && state == LOAD) begin
            frame <= {frame[CFG_W-2:0], bus.DIN};
            acc <= acc ^ bus.DIN;
            cnt <= cnt + 1'b1;
         end else if (bus.CE && state == PAR) begin
            sync_reg <= '0;
            err <= !commit;
            if (commit) cfg <= frame;
         end
      end
   assign bus.CFG = cfg;
   assign bus.DONE = done;
   assign bus.ERR = err;
   assign bus.BUSY = state != HUNT;
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: directed checks of sync hunt, frame load, parity commit and reset.
module tb_clb_cfg_loader;
   localparam logic [36:0] RST_VAL = 37'h0_22C5_4038;
   localparam logic [36:0] P1 = 37'h1_2345_6789;
   localparam logic [36:0] P2 = 37'h0_0F0F_00FF;
   localparam logic [36:0] P3 = 37'h0_B2B2_B2B2;
   logic K = 1'b0;
   logic RST = 1'b0;
   int total = 0;
   int bad = 0;
   int busy_cnt = 0;
   clb_cfg_loader_if #(.CFG_W(37)) bus ();
   clb_cfg_loader dut (.K(K), .RST(RST), .bus(bus));
   always #5 K = ~K;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic bit_in(input logic b, input logic ce);
      bus.DIN = b;
      bus.CE = ce;
      @(posedge K);
      #1;
      if (bus.BUSY === 1'b1) busy_cnt++;
   endtask
   task automatic send(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bit_in(v[i], 1'b1);
   endtask
   initial begin
      bus.CE = 1'b0;
      bus.DIN = 1'b0;
      #3 RST = 1'b1;
      #1;
      chk("rst_cfg", 64'(bus.CFG), 64'(RST_VAL));
      chk("rst_done", 64'(bus.DONE), 0);
      chk("rst_busy", 64'(bus.BUSY), 0);
      chk("rst_err", 64'(bus.ERR), 0);
      @(negedge K) RST = 1'b0;
      @(posedge K);
      #1;
      // good frame
      busy_cnt = 0;
      send(64'hB2, 8);
      chk("sync_busy", 64'(bus.BUSY), 1);
      send(64'(P1 >> 1), 36);
      chk("no_partial", 64'(bus.CFG), 64'(RST_VAL));
      bit_in(P1[0], 1'b1);
      bit_in(^P1, 1'b1);
      chk("good_cfg", 64'(bus.CFG), 64'(P1));
      chk("good_done", 64'(bus.DONE), 1);
      chk("good_err", 64'(bus.ERR), 0);
      chk("good_busy_len", 64'(busy_cnt), 38);
      bit_in(1'b0, 1'b1);
      chk("done_pulse", 64'(bus.DONE), 0);
      // bad parity
      send(64'hB2, 8);
      send(64'(P2), 37);
      bit_in(~^P2, 1'b1);
      chk("bad_cfg", 64'(bus.CFG), 64'(P1));
      chk("bad_done", 64'(bus.DONE), 0);
      chk("bad_err", 64'(bus.ERR), 1);
      send(64'h59, 7);
      chk("err_sticky", 64'(bus.ERR), 1);
      bit_in(1'b0, 1'b1);
      chk("err_clear", 64'(bus.ERR), 0);
      send(64'(P2), 37);
      bit_in(^P2, 1'b1);
      chk("even_cfg", 64'(bus.CFG), 64'(P2));
      chk("even_done", 64'(bus.DONE), 1);
      // CE gap mid-payload
      busy_cnt = 0;
      send(64'hB2, 8);
      send(64'(P1 >> 17), 20);
      for (int i = 0; i < 5; i++) bit_in(i[0], 1'b0);
      send(64'(P1), 17);
      bit_in(^P1, 1'b1);
      chk("gap_cfg", 64'(bus.CFG), 64'(P1));
      chk("gap_busy_len", 64'(busy_cnt), 43);
      bit_in(1'b1, 1'b0);
      chk("gap_done_fall", 64'(bus.DONE), 0);
      // false-sync prefix then a payload full of sync bytes
      send(64'hB3, 8);
      chk("false_sync", 64'(bus.BUSY), 0);
      send(64'h59, 7);
      chk("pre_sync", 64'(bus.BUSY), 0);
      busy_cnt = 0;
      bit_in(1'b0, 1'b1);
      send(64'(P3), 37);
      bit_in(^P3, 1'b1);
      chk("embed_cfg", 64'(bus.CFG), 64'(P3));
      chk("embed_done", 64'(bus.DONE), 1);
      chk("embed_busy_len", 64'(busy_cnt), 38);
      // reset mid-load
      send(64'hB2, 8);
      send(64'(P1 >> 27), 10);
      #2 RST = 1'b1;
      #1;
      chk("midrst_cfg", 64'(bus.CFG), 64'(RST_VAL));
      chk("midrst_busy", 64'(bus.BUSY), 0);
      RST = 1'b0;
      @(posedge K);
      #1;
      busy_cnt = 0;
      send(64'hB2, 8);
      send(64'(P1), 37);
      bit_in(^P1, 1'b1);
      chk("post_rst_cfg", 64'(bus.CFG), 64'(P1));
      chk("post_rst_done", 64'(bus.DONE), 1);
      chk("post_rst_busy_len", 64'(busy_cnt), 38);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
